sensor_win_pack: RTL and testbench

SENSOR_WIN_PACK -- requirements
Module: sensor_win_pack

---
 rtl/sensor_win_pack.sv | 264 ++++++++++++++++++++++++++
 tb/tb_sensor_win_pack.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_win_pack.sv
// sensor_win_pack: crops a window out of a raster sensor stream and packs
// in-window 8-bit pixels into 16-bit pairs, marking the final word of each
// line and pulsing frame_done when a bounded window has been fully emitted.
module sensor_win_pack (
   input  logic        pclk,
   input  logic        prst_n,
   input  logic        en,
   input  logic        sof,
   input  logic        hact,
   input  logic [7:0]  pxd,
   input  logic [13:0] win_left,
   input  logic [13:0] win_width,
   input  logic [15:0] win_top,
   input  logic [15:0] win_height,
   output logic [15:0] px_data,
   output logic        px_valid,
   output logic        last_in_line,
   output logic        frame_done,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_FRAME, S_FLUSH, S_SKIP} state_t;

   state_t      state_q, state_d;

   // window shadow copies, frozen for the whole frame
   logic [13:0] left_q, left_d, width_q, width_d;
   logic [15:0] top_q, top_d, height_q, height_d;

   // raster position
   logic [13:0] xcnt_q, xcnt_d;
   logic [15:0] ycnt_q, ycnt_d;
   logic        hact_q;
   logic        sofskip_q, sofskip_d;

   // packing storage
   logic [7:0]  half_q, half_d;
   logic        half_vld_q, half_vld_d;
   logic [15:0] hold_q, hold_d;
   logic        hold_vld_q, hold_vld_d;
   logic [15:0] sec_q, sec_d;
   logic        sec_vld_q, sec_vld_d;
   logic        lastl_q, lastl_d;

   // output registers
   logic [15:0] out_data_q, out_data_d;
   logic        out_vld_q, out_vld_d;
   logic        out_last_q, out_last_d;
   logic        done_pend_q, done_pend_d;
   logic        done_q, done_d;

   // window decode; sums are one bit wider so they never wrap
   logic [14:0] x_lim;
   logic [16:0] y_lim;
   logic        x_in, x_last, y_in, y_last;
   logic        hact_fall, pix_in, win_end, line_end;
   logic        pair_done, emit_old;
   logic [15:0] pair_w, hold_n;
   logic        hv_n, halfv_n;
   logic [7:0]  half_n;

   assign x_lim   = {1'b0, left_q} + {1'b0, width_q};
   assign y_lim   = {1'b0, top_q} + {1'b0, height_q};
   assign x_in    = (xcnt_q >= left_q) && ((width_q == 14'd0) || ({1'b0, xcnt_q} < x_lim));
   assign x_last  = (width_q != 14'd0) && ({1'b0, xcnt_q} == (x_lim - 15'd1));
   assign y_in    = (ycnt_q >= top_q) && ((height_q == 16'd0) || ({1'b0, ycnt_q} < y_lim));
   assign y_last  = (height_q != 16'd0) && ({1'b0, ycnt_q} == (y_lim - 17'd1));

   assign hact_fall = hact_q & ~hact;
   assign pix_in    = (state_q == S_FRAME) && !sof && hact && x_in && y_in;
   assign win_end   = pix_in && x_last;
   assign line_end  = (state_q == S_FRAME) && !sof && (hact_fall || win_end);

   // packing state as it stands after absorbing this cycle's pixel
   assign pair_done = pix_in && half_vld_q;
   assign pair_w    = {pxd, half_q};
   assign emit_old  = pair_done && hold_vld_q;
   assign hold_n    = pair_done ? pair_w : hold_q;
   assign hv_n      = pair_done || hold_vld_q;
   assign half_n    = (pix_in && !half_vld_q) ? pxd : half_q;
   assign halfv_n   = pix_in ? !half_vld_q : half_vld_q;

   assign busy         = (state_q != S_IDLE);
   assign px_data      = out_data_q;
   assign px_valid     = out_vld_q;
   assign last_in_line = out_last_q;
   assign frame_done   = done_q;

   // words owed at a line end: at most two, the second goes out from FLUSH
   logic [15:0] w0, w1;
   logic [1:0]  nw;

   // line-end drain list built from the post-pixel packing state
   always_comb begin
      w0 = 16'h0000;
      w1 = 16'h0000;
      nw = 2'd0;
      if (emit_old) begin
         w0 = hold_q;
         w1 = pair_w;
         nw = 2'd2;
      end else if (hv_n && halfv_n) begin
         w0 = hold_n;
         w1 = {8'h00, half_n};
         nw = 2'd2;
      end else if (hv_n) begin
         w0 = hold_n;
         nw = 2'd1;
      end else if (halfv_n) begin
         w0 = {8'h00, half_n};
         nw = 2'd1;
      end
   end

   // next-state and datapath decisions; sof overrides everything
   always_comb begin
      state_d     = state_q;
      left_d      = left_q;
      width_d     = width_q;
      top_d       = top_q;
      height_d    = height_q;
      half_d      = half_q;
      half_vld_d  = half_vld_q;
      hold_d      = hold_q;
      hold_vld_d  = hold_vld_q;
      sec_d       = sec_q;
      sec_vld_d   = sec_vld_q;
      lastl_d     = lastl_q;
      out_data_d  = out_data_q;
      out_vld_d   = 1'b0;
      out_last_d  = 1'b0;
      done_pend_d = 1'b0;
      done_d      = done_pend_q;
      xcnt_d      = hact ? (xcnt_q + 14'd1) : 14'd0;
      ycnt_d      = ycnt_q;
      sofskip_d   = sofskip_q;

      // a sof arriving mid-line must not count that line's end as a new line
      if (sof) begin
         ycnt_d    = 16'd0;
         sofskip_d = hact;
      end else if (hact_fall) begin
         sofskip_d = 1'b0;
         if (!sofskip_q) ycnt_d = ycnt_q + 16'd1;
      end

      if (sof) begin
         half_vld_d = 1'b0;
         hold_vld_d = 1'b0;
         sec_vld_d  = 1'b0;
         if (busy && (height_q == 16'd0)) done_d = 1'b1;
         if (en) begin
            left_d   = win_left;
            width_d  = win_width;
            top_d    = win_top;
            height_d = win_height;
            state_d  = hact ? S_SKIP : S_FRAME;
         end else begin
            state_d = S_IDLE;
         end
      end else begin
         case (state_q)
            S_FRAME: begin
               if (line_end) begin
                  half_vld_d = 1'b0;
                  hold_vld_d = 1'b0;
                  lastl_d    = y_last;
                  sec_d      = w1;
                  sec_vld_d  = (nw == 2'd2);
                  if (nw != 2'd0) begin
                     out_vld_d   = 1'b1;
                     out_data_d  = w0;
                     out_last_d  = (nw == 2'd1);
                     done_pend_d = (nw == 2'd1) && y_last;
                     state_d     = S_FLUSH;
                  end else if (y_last) begin
                     done_pend_d = 1'b1;
                     state_d     = S_IDLE;
                  end
               end else begin
                  if (emit_old) begin
                     out_vld_d  = 1'b1;
                     out_data_d = hold_q;
                  end
                  hold_d     = hold_n;
                  hold_vld_d = hv_n;
                  half_d     = half_n;
                  half_vld_d = halfv_n;
               end
            end
            S_FLUSH: begin
               if (sec_vld_q) begin
                  out_vld_d   = 1'b1;
                  out_last_d  = 1'b1;
                  out_data_d  = sec_q;
                  done_pend_d = lastl_q;
               end
               sec_vld_d = 1'b0;
               if (lastl_q)   state_d = S_IDLE;
               else if (hact) state_d = S_SKIP;
               else           state_d = S_FRAME;
            end
            S_SKIP: begin
               if (!hact) state_d = S_FRAME;
            end
            default: ;
         endcase
      end
   end

   // state register
   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // datapath, counters and output registers
   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         left_q      <= '0;
         width_q     <= '0;
         top_q       <= '0;
         height_q    <= '0;
         xcnt_q      <= '0;
         ycnt_q      <= '0;
         hact_q      <= 1'b0;
         sofskip_q   <= 1'b0;
         half_q      <= '0;
         half_vld_q  <= 1'b0;
         hold_q      <= '0;
         hold_vld_q  <= 1'b0;
         sec_q       <= '0;
         sec_vld_q   <= 1'b0;
         lastl_q     <= 1'b0;
         out_data_q  <= '0;
         out_vld_q   <= 1'b0;
         out_last_q  <= 1'b0;
         done_pend_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         left_q      <= left_d;
         width_q     <= width_d;
         top_q       <= top_d;
         height_q    <= height_d;
         xcnt_q      <= xcnt_d;
         ycnt_q      <= ycnt_d;
         hact_q      <= hact;
         sofskip_q   <= sofskip_d;
         half_q      <= half_d;
         half_vld_q  <= half_vld_d;
         hold_q      <= hold_d;
         hold_vld_q  <= hold_vld_d;
         sec_q       <= sec_d;
         sec_vld_q   <= sec_vld_d;
         lastl_q     <= lastl_d;
         out_data_q  <= out_data_d;
         out_vld_q   <= out_vld_d;
         out_last_q  <= out_last_d;
         done_pend_q <= done_pend_d;
         done_q      <= done_d;
      end
   end

endmodule

// File: tb/tb_sensor_win_pack.sv
// Directed bench for sensor_win_pack: each task drives one scenario and
// checks captured output words against hand-computed values.
module tb_sensor_win_pack;

   logic        pclk = 1'b0;
   logic        prst_n = 1'b1;
   logic        en = 1'b0, sof = 1'b0, hact = 1'b0;
   logic [7:0]  pxd = 8'h00;
   logic [13:0] win_left = '0, win_width = '0;
   logic [15:0] win_top = '0, win_height = '0;
   logic [15:0] px_data;
   logic        px_valid, last_in_line, frame_done, busy;

   int n_run = 0, n_fail = 0;
   int cyc = 0;
   logic [15:0] cap_d[$];
   logic        cap_l[$];
   int fd_cnt = 0, fd_cyc = 0, last_cyc = 0;

   sensor_win_pack dut (
      .pclk(pclk), .prst_n(prst_n), .en(en), .sof(sof), .hact(hact), .pxd(pxd),
      .win_left(win_left), .win_width(win_width), .win_top(win_top), .win_height(win_height),
      .px_data(px_data), .px_valid(px_valid), .last_in_line(last_in_line),
      .frame_done(frame_done), .busy(busy)
   );

   always #5 pclk = ~pclk;

   always @(posedge pclk) cyc <= cyc + 1;

   // output capture on the falling edge
   always @(negedge pclk) begin
      if (px_valid === 1'b1) begin
         cap_d.push_back(px_data);
         cap_l.push_back(last_in_line);
         if (last_in_line === 1'b1) last_cyc = cyc;
      end
      if (frame_done === 1'b1) begin
         fd_cnt++;
         fd_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_sof();
      sof = 1'b1;
      tick();
      sof = 1'b0;
   endtask

   task automatic drive_line(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         hact = 1'b1;
         pxd  = base + 8'(i);
         tick();
      end
      hact = 1'b0;
      pxd  = 8'h00;
      idle(3);
   endtask

   task automatic clr();
      cap_d.delete();
      cap_l.delete();
      fd_cnt = 0;
   endtask

   task automatic set_win(input logic [13:0] l, input logic [13:0] w,
                          input logic [15:0] t, input logic [15:0] h);
      win_left = l; win_width = w; win_top = t; win_height = h;
   endtask

   task automatic test_reset();
      #2 prst_n = 1'b0;
      #1;
      n_run++; if (px_data !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", px_data); end
      n_run++; if (px_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", px_valid); end
      n_run++; if (last_in_line !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", last_in_line); end
      n_run++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", frame_done); end
      n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      idle(2);
      prst_n = 1'b1;
      idle(2);
      drive_line(8, 8'h00);
      n_run++; if (cap_d.size() !== 0) begin n_fail++; $display("FAIL reset_nosof_words: got %0d expected 0", cap_d.size()); end
      n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_nosof_busy: got %b expected 0", busy); end
   endtask

   task automatic test_full_window();
      logic [15:0] exp_w [4] = '{16'h0100, 16'h0302, 16'h0504, 16'h0706};
      clr();
      en = 1'b1;
      set_win(0, 0, 0, 0);
      pulse_sof();
      idle(2);
      for (int l = 0; l < 3; l++) drive_line(8, 8'h00);
      n_run++; if (cap_d.size() !== 12) begin n_fail++; $display("FAIL full_count: got %0d expected 12", cap_d.size()); end
      for (int i = 0; i < 12; i++) begin
         n_run++;
         if (i >= cap_d.size() || cap_d[i] !== exp_w[i % 4] || cap_l[i] !== ((i % 4) == 3)) begin
            n_fail++;
            $display("FAIL full_word%0d: got %h/%b expected %h/%b", i,
                     (i < cap_d.size()) ? cap_d[i] : 16'hxxxx, (i < cap_l.size()) ? cap_l[i] : 1'bx,
                     exp_w[i % 4], ((i % 4) == 3));
         end
      end
      n_run++; if (fd_cnt !== 0) begin n_fail++; $display("FAIL full_nodone: got %0d expected 0", fd_cnt); end
      n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy: got %b expected 1", busy); end
   endtask

   task automatic test_hwin();
      logic [15:0] exp_w [3] = '{16'h0201, 16'h0403, 16'h0005};
      logic        exp_l [3] = '{1'b0, 1'b0, 1'b1};
      clr();
      set_win(1, 5, 0, 0);
      pulse_sof();
      idle(2);
      n_run++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL hwin_sof_done: got %0d expected 1", fd_cnt); end
      clr();
      drive_line(10, 8'h00);
      n_run++; if (cap_d.size() !== 3) begin n_fail++; $display("FAIL hwin_count: got %0d expected 3", cap_d.size()); end
      for (int i = 0; i < 3; i++) begin
         n_run++;
         if (i >= cap_d.size() || cap_d[i] !== exp_w[i] || cap_l[i] !== exp_l[i]) begin
            n_fail++;
            $display("FAIL hwin_word%0d: got %h/%b expected %h/%b", i,
                     (i < cap_d.size()) ? cap_d[i] : 16'hxxxx, (i < cap_l.size()) ? cap_l[i] : 1'bx,
                     exp_w[i], exp_l[i]);
         end
      end
   endtask

   task automatic test_vwin();
      logic [15:0] exp_w [8] = '{16'h1110, 16'h1312, 16'h1514, 16'h1716,
                                 16'h2120, 16'h2322, 16'h2524, 16'h2726};
      set_win(0, 0, 1, 2);
      pulse_sof();
      en = 1'b0;
      idle(2);
      clr();
      drive_line(8, 8'h00);
      drive_line(8, 8'h10);
      drive_line(8, 8'h20);
      drive_line(8, 8'h30);
      n_run++; if (cap_d.size() !== 8) begin n_fail++; $display("FAIL vwin_count: got %0d expected 8", cap_d.size()); end
      for (int i = 0; i < 8; i++) begin
         n_run++;
         if (i >= cap_d.size() || cap_d[i] !== exp_w[i] || cap_l[i] !== ((i % 4) == 3)) begin
            n_fail++;
            $display("FAIL vwin_word%0d: got %h/%b expected %h/%b", i,
                     (i < cap_d.size()) ? cap_d[i] : 16'hxxxx, (i < cap_l.size()) ? cap_l[i] : 1'bx,
                     exp_w[i], ((i % 4) == 3));
         end
      end
      n_run++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL vwin_done_cnt: got %0d expected 1", fd_cnt); end
      n_run++; if (fd_cyc !== last_cyc + 1) begin n_fail++; $display("FAIL vwin_done_time: got %0d expected %0d", fd_cyc, last_cyc + 1); end
      n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL vwin_busy: got %b expected 0", busy); end
      en = 1'b1;
   endtask

   task automatic test_left_beyond();
      clr();
      set_win(20, 0, 0, 0);
      pulse_sof();
      idle(2);
      drive_line(8, 8'h00);
      n_run++; if (cap_d.size() !== 0) begin n_fail++; $display("FAIL left20_count: got %0d expected 0", cap_d.size()); end
      n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL left20_busy: got %b expected 1", busy); end
   endtask

   task automatic test_sof_abort();
      logic [15:0] exp_w [4] = '{16'h4140, 16'h4342, 16'h4544, 16'h4746};
      set_win(0, 0, 0, 0);
      pulse_sof();
      idle(2);
      clr();
      for (int i = 0; i < 8; i++) begin
         hact = 1'b1;
         pxd  = 8'h30 + 8'(i);
         sof  = (i == 3);
         tick();
      end
      sof = 1'b0;
      hact = 1'b0;
      idle(3);
      n_run++; if (cap_d.size() !== 0) begin n_fail++; $display("FAIL abort_words: got %0d expected 0", cap_d.size()); end
      drive_line(8, 8'h40);
      n_run++; if (cap_d.size() !== 4) begin n_fail++; $display("FAIL abort_count: got %0d expected 4", cap_d.size()); end
      for (int i = 0; i < 4; i++) begin
         n_run++;
         if (i >= cap_d.size() || cap_d[i] !== exp_w[i] || cap_l[i] !== (i == 3)) begin
            n_fail++;
            $display("FAIL abort_word%0d: got %h/%b expected %h/%b", i,
                     (i < cap_d.size()) ? cap_d[i] : 16'hxxxx, (i < cap_l.size()) ? cap_l[i] : 1'bx,
                     exp_w[i], (i == 3));
         end
      end
   endtask

   task automatic test_reset_mid();
      clr();
      for (int i = 0; i < 4; i++) begin
         hact = 1'b1;
         pxd  = 8'(i);
         tick();
      end
      n_run++; if (px_valid !== 1'b1 || px_data !== 16'h0100) begin n_fail++; $display("FAIL rmid_pre: got %b/%h expected 1/0100", px_valid, px_data); end
      #2 prst_n = 1'b0;
      #1;
      n_run++; if (px_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", px_valid); end
      n_run++; if (px_data !== 16'h0) begin n_fail++; $display("FAIL rmid_data: got %h expected 0000", px_data); end
      n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
      hact = 1'b0;
      idle(2);
      #2 prst_n = 1'b1;
      tick();
      clr();
      drive_line(8, 8'h60);
      drive_line(8, 8'h70);
      n_run++; if (cap_d.size() !== 0) begin n_fail++; $display("FAIL rmid_nosof: got %0d expected 0", cap_d.size()); end
   endtask

   initial begin
      test_reset();
      test_full_window();
      test_hwin();
      test_vwin();
      test_left_beyond();
      test_sof_abort();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
